video_down_scaler_v1_5_ctrl_master: RTL
=======================================

// Module: video_down_scaler_v1_5_ctrl_master
// PURPOSE: AXI4-Lite initiator that programs the down-scaler CTRL register block for one frame.
//   It writes geometry and logo window, sets run, polls control until done, then clears control with a reset write.
//   Sits between a host-side sequencer (start/cfg) and the scaler's CTRL AXI4-Lite slave port.
// PARAMETERS:
//   CTRL_AXI_DATA_WIDTH  32    AXI-Lite data width and width of each cfg field
//   CTRL_AXI_ADDR_WIDTH  8     AXI-Lite address width
//   POLL_GAP             16    idle cycles between consecutive status reads (0 allowed)
//   POLL_LIMIT           1024  max status reads before timeout error (>=1)
// PORTS: (DW=CTRL_AXI_DATA_WIDTH, AW=CTRL_AXI_ADDR_WIDTH)
//   M_AXI_ACLK      in   1     single clock
//   M_AXI_ARESET    in   1     reset, synchronous, active-high
//   start           in   1     begin frame sequence; ignored unless IDLE
//   cfg_dims        in   4*DW  {dst_heigth,dst_width,src_heigth,src_width}; [DW-1:0]=src_width
//   cfg_logo        in   4*DW  {vend,vbegin,hend,hbegin}; [DW-1:0]=logo_hlocation_begin
//   cfg_logo_valid  in   1     copied to control bit3 in the run write
//   busy            out  1     high while not IDLE
//   done            out  1     1-cycle pulse on successful completion
//   error           out  1     sticky; BRESP!=0 or poll timeout; cleared on accepted start
//   status          out  DW    last control value read
//   M_AXI_AWADDR    out  AW    write address
//   M_AXI_AWVALID   out  1     write address valid
//   M_AXI_AWREADY   in   1     write address ready
//   M_AXI_WDATA     out  DW    write data
//   M_AXI_WVALID    out  1     write data valid
//   M_AXI_WREADY    in   1     write data ready
//   M_AXI_BRESP     in   2     write response
//   M_AXI_BVALID    in   1     write response valid
//   M_AXI_BREADY    out  1     write response ready
//   M_AXI_ARADDR    out  AW    read address (always 0x00)
//   M_AXI_ARVALID   out  1     read address valid
//   M_AXI_ARREADY   in   1     read address ready
//   M_AXI_RDATA     in   DW    read data
//   M_AXI_RVALID    in   1     read data valid
//   M_AXI_RREADY    out  1     read data ready
// BEHAVIOUR:
// - Reset: state IDLE. All outputs 0 (VALIDs, READYs, addresses, WDATA, busy, done, error, status). Step and poll counters 0.
// - start in IDLE: latch cfg_* internally; later cfg changes have no effect. busy=1 from next cycle; error<=0.
// - Steps (addr:data):
//     0 0x04:src_width      1 0x08:src_heigth    2 0x0C:dst_width     3 0x10:dst_heigth
//     4 0x24:hbegin         5 0x28:hend          6 0x2C:vbegin        7 0x30:vend
//     8 0x00:{logo_valid,3'b001}  (0x1 or 0x9)
//     9 0x00:0x2 (reset bit), issued after done is seen
// - FSM: IDLE->WR->WR_RESP; WR_RESP->WR (steps 0-7) | RD (after step 8) | IDLE+done (after step 9).
//   RD->RD_DATA->(RDATA[2] ? WR step 9 : GAP). GAP->RD after POLL_GAP cycles.
// - WR: AWVALID and WVALID rise in the same cycle, because the slave accepts only when both are valid.
//   Addr/data are stable until accepted. Each VALID drops the cycle after its own READY is sampled.
//   Leave WR once both are accepted.
// - WR_RESP: BREADY=1. On BVALID with BRESP!=0: error<=1 and go to IDLE (no done, no further traffic). Otherwise advance.
// - RD: ARVALID=1 until ARREADY. RD_DATA: RREADY=1; on RVALID, status<=RDATA and poll_cnt++.
//   If poll_cnt reaches POLL_LIMIT without RDATA[2]: error<=1, go to IDLE, skip step 9.
// - Exactly one transaction outstanding; write and read channels never overlap.
// - Zero-wait slave: each write and each read occupies 3 cycles (VALID, READY, B/R handshake).
// - done pulses in the cycle state==IDLE is re-entered (busy=0 that cycle). A start in that same cycle is accepted.
// - Reset mid-sequence: next edge returns all outputs to reset values; the pending response is discarded.
// TESTING:
// 1 Hold reset 3 cycles -> every output 0, no VALID asserted; start during reset is ignored.
// 2 src 1920x1080, dst 640x360, logo (16,80,8,40) valid; slave sets done after 3rd read
//   -> writes 0x780,0x438,0x280,0x168,0x10,0x50,0x8,0x28, then 0x9 @0x00, 3 reads, 0x2 @0x00;
//   done pulses once; status=0x4; error=0.
// 3 Slave holds AWREADY low 4 cycles and WREADY low 1 cycle -> WVALID drops first, AWVALID held;
//   AWADDR/WDATA stay stable; step sequence unchanged.
// 4 BRESP=2'b10 on step 3 -> error=1 and busy=0 next cycle; no further AW/AR; done never pulses.
// 5 POLL_LIMIT=4, POLL_GAP=2, done never set -> exactly 4 reads with 2 idle cycles between; error=1; no step-9 write.
// 6 Reset asserted in GAP -> outputs 0 next cycle; start while busy and cfg change mid-frame -> no effect on the running sequence.

Source files
------------

// File: rtl/video_down_scaler_v1_5_ctrl_master.sv
// AXI4-Lite initiator that programs the down-scaler CTRL block for one frame:
// geometry and logo writes, run, poll for done, then a control reset write.
module video_down_scaler_v1_5_ctrl_master #(
  parameter int unsigned CTRL_AXI_DATA_WIDTH = 32,
  parameter int unsigned CTRL_AXI_ADDR_WIDTH = 8,
  parameter int unsigned POLL_GAP            = 16,
  parameter int unsigned POLL_LIMIT          = 1024
) (
  input  logic                             M_AXI_ACLK,
  input  logic                             M_AXI_ARESET,
  input  logic                             start,
  input  logic [4*CTRL_AXI_DATA_WIDTH-1:0] cfg_dims,
  input  logic [4*CTRL_AXI_DATA_WIDTH-1:0] cfg_logo,
  input  logic                             cfg_logo_valid,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [CTRL_AXI_DATA_WIDTH-1:0]   status,
  output logic [CTRL_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                             M_AXI_AWVALID,
  input  logic                             M_AXI_AWREADY,
  output logic [CTRL_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic                             M_AXI_WVALID,
  input  logic                             M_AXI_WREADY,
  input  logic [1:0]                       M_AXI_BRESP,
  input  logic                             M_AXI_BVALID,
  output logic                             M_AXI_BREADY,
  output logic [CTRL_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                             M_AXI_ARVALID,
  input  logic                             M_AXI_ARREADY,
  input  logic [CTRL_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic                             M_AXI_RVALID,
  output logic                             M_AXI_RREADY
);

  localparam int unsigned DW = CTRL_AXI_DATA_WIDTH;
  localparam int unsigned AW = CTRL_AXI_ADDR_WIDTH;
  localparam int unsigned PW = $clog2(POLL_LIMIT + 1);
  localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD, S_RD_DATA, S_GAP
  } state_t;

  state_t            state;
  logic [3:0]        step;
  logic [PW-1:0]     poll_cnt;
  logic [GW-1:0]     gap_cnt;
  logic              aw_ok;
  logic              w_ok;
  logic [4*DW-1:0]   dims_q;
  logic [4*DW-1:0]   logo_q;
  logic              logo_valid_q;

  // Status reads always target the control register at offset 0.
  assign M_AXI_ARADDR = '0;

  function automatic logic [AW-1:0] step_addr(input logic [3:0] s);
    logic [AW-1:0] r;
    case (s)
      4'd0:    r = AW'(8'h04);
      4'd1:    r = AW'(8'h08);
      4'd2:    r = AW'(8'h0C);
      4'd3:    r = AW'(8'h10);
      4'd4:    r = AW'(8'h24);
      4'd5:    r = AW'(8'h28);
      4'd6:    r = AW'(8'h2C);
      4'd7:    r = AW'(8'h30);
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [DW-1:0] step_data(input logic [3:0] s);
    logic [DW-1:0] r;
    case (s)
      4'd0:    r = dims_q[0*DW +: DW];
      4'd1:    r = dims_q[1*DW +: DW];
      4'd2:    r = dims_q[2*DW +: DW];
      4'd3:    r = dims_q[3*DW +: DW];
      4'd4:    r = logo_q[0*DW +: DW];
      4'd5:    r = logo_q[1*DW +: DW];
      4'd6:    r = logo_q[2*DW +: DW];
      4'd7:    r = logo_q[3*DW +: DW];
      4'd8:    r = DW'({logo_valid_q, 3'b001});
      default: r = DW'(2);
    endcase
    return r;
  endfunction

  // Sequencer: one AXI-Lite transaction outstanding at a time.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state         <= S_IDLE;
      step          <= '0;
      poll_cnt      <= '0;
      gap_cnt       <= '0;
      aw_ok         <= 1'b0;
      w_ok          <= 1'b0;
      dims_q        <= '0;
      logo_q        <= '0;
      logo_valid_q  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      status        <= '0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            dims_q        <= cfg_dims;
            logo_q        <= cfg_logo;
            logo_valid_q  <= cfg_logo_valid;
            busy          <= 1'b1;
            error         <= 1'b0;
            step          <= '0;
            poll_cnt      <= '0;
            aw_ok         <= 1'b0;
            w_ok          <= 1'b0;
            M_AXI_AWADDR  <= AW'(8'h04);
            M_AXI_WDATA   <= cfg_dims[DW-1:0];
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            state         <= S_WR;
          end
        end
        S_WR: begin
          if (M_AXI_AWVALID && M_AXI_AWREADY) begin
            M_AXI_AWVALID <= 1'b0;
            aw_ok         <= 1'b1;
          end
          if (M_AXI_WVALID && M_AXI_WREADY) begin
            M_AXI_WVALID <= 1'b0;
            w_ok         <= 1'b1;
          end
          if ((aw_ok || (M_AXI_AWVALID && M_AXI_AWREADY)) &&
              (w_ok  || (M_AXI_WVALID  && M_AXI_WREADY))) begin
            aw_ok        <= 1'b0;
            w_ok         <= 1'b0;
            M_AXI_BREADY <= 1'b1;
            state        <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            if (M_AXI_BRESP != 2'b00) begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else if (step == 4'd9) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else if (step == 4'd8) begin
              poll_cnt      <= '0;
              M_AXI_ARVALID <= 1'b1;
              state         <= S_RD;
            end else begin
              step          <= step + 4'd1;
              M_AXI_AWADDR  <= step_addr(step + 4'd1);
              M_AXI_WDATA   <= step_data(step + 4'd1);
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              state         <= S_WR;
            end
          end
        end
        S_RD: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            status       <= M_AXI_RDATA;
            poll_cnt     <= poll_cnt + PW'(1);
            if (M_AXI_RDATA[2]) begin
              step          <= 4'd9;
              M_AXI_AWADDR  <= '0;
              M_AXI_WDATA   <= DW'(2);
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              state         <= S_WR;
            end else if (poll_cnt + PW'(1) == PW'(POLL_LIMIT)) begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else if (POLL_GAP == 0) begin
              M_AXI_ARVALID <= 1'b1;
              state         <= S_RD;
            end else begin
              gap_cnt <= '0;
              state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GW'(POLL_GAP - 1)) begin
            M_AXI_ARVALID <= 1'b1;
            state         <= S_RD;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
